// File: rtl/pwm_pkg.sv
// Shared PWM definitions for the generator and capture paths.
// Holds the default counter widths and the capture FSM state type.
package pwm_pkg;

  // Default frame counter / result width.
  localparam int unsigned PwmWidth = 13;
  // Default pulse counter width.
  localparam int unsigned PwmPcntW = 4;

  typedef enum logic {
    StIdle,
    StMeasure
  } cap_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the PWM input under measurement.
// Ports:
//   clk_in   - system clock
//   rst_in   - synchronous, active-high reset (output clears to 0)
//   pwm_in   - asynchronous PWM waveform
//   pwm_sync - waveform retimed to clk_in, two cycles late
module pwm_in_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pwm_in,
  output logic pwm_sync
);

  logic meta_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q   <= 1'b0;
      pwm_sync <= 1'b0;
    end else begin
      meta_q   <= pwm_in;
      pwm_sync <= meta_q;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Frame-by-frame PWM measurement: recovers offset, high time, pulse count and
// frame length of a gate waveform, framed by a carrier-aligned start strobe.
// Optional macro PWM_CAP_SYNC_EN inserts a 2-flop input synchronizer.
// Ports:
//   clk_in      - system clock
//   rst_in      - synchronous, active-high reset
//   frame_start - one-cycle strobe, its cycle is count 0 of a new frame
//   pwm_in      - PWM waveform under measurement
//   offset_out  - count of first rising edge in last completed frame
//   duty_out    - high cycles in last completed frame
//   period_out  - cycles in last completed frame
//   pulse_cnt   - rising edges in last completed frame
//   no_pulse    - last completed frame had no rising edge
//   overrun     - frame counter saturated during last completed frame
//   meas_valid  - one-cycle strobe, result outputs updated
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH  = PwmWidth,
  parameter int unsigned PCNT_W = PwmPcntW
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start,
  input  logic              pwm_in,
  output logic [WIDTH-1:0]  offset_out,
  output logic [WIDTH-1:0]  duty_out,
  output logic [WIDTH-1:0]  period_out,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic              no_pulse,
  output logic              overrun,
  output logic              meas_valid
);

  localparam logic [WIDTH-1:0]  CntMax   = '1;
  localparam logic [WIDTH-1:0]  CntOne   = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [PCNT_W-1:0] PulseMax = '1;
  localparam logic [PCNT_W-1:0] PulseOne = {{(PCNT_W - 1){1'b0}}, 1'b1};

  logic pwm_s;

`ifdef PWM_CAP_SYNC_EN
  pwm_in_sync u_pwm_in_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .pwm_in  (pwm_in),
    .pwm_sync(pwm_s)
  );
`else
  assign pwm_s = pwm_in;
`endif

  cap_state_e        state_q;
  logic [WIDTH-1:0]  cnt_q, high_q, offset_q;
  logic [PCNT_W-1:0] pulses_q;
  logic              ovf_q, seen_q, pwm_prev_q;

  // Values for the current cycle, with frame_start restarting the frame.
  logic [WIDTH-1:0]  cnt_cur, high_base, offset_base, high_nxt, offset_nxt, period_nxt;
  logic [PCNT_W-1:0] pulses_base, pulses_nxt;
  logic              seen_base, ovf_base, seen_nxt, ovf_nxt, rise;

  always_comb begin
    cnt_cur     = frame_start ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + CntOne);
    high_base   = frame_start ? '0 : high_q;
    offset_base = frame_start ? '0 : offset_q;
    pulses_base = frame_start ? '0 : pulses_q;
    seen_base   = frame_start ? 1'b0 : seen_q;
    ovf_base    = frame_start ? 1'b0 : ovf_q;

    // Count 0 always qualifies, so a level held high across the boundary is an edge.
    rise = pwm_s & (frame_start | ~pwm_prev_q);

    high_nxt   = (pwm_s && high_base != CntMax) ? high_base + CntOne : high_base;
    pulses_nxt = (rise && pulses_base != PulseMax) ? pulses_base + PulseOne : pulses_base;
    offset_nxt = (rise && !seen_base) ? cnt_cur : offset_base;
    seen_nxt   = seen_base | rise;
    ovf_nxt    = ovf_base | (cnt_cur == CntMax);

    // Length of the frame being closed: last count plus one, saturated.
    period_nxt = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      high_q     <= '0;
      offset_q   <= '0;
      pulses_q   <= '0;
      ovf_q      <= 1'b0;
      seen_q     <= 1'b0;
      pwm_prev_q <= 1'b0;
      offset_out <= '0;
      duty_out   <= '0;
      period_out <= '0;
      pulse_cnt  <= '0;
      no_pulse   <= 1'b0;
      overrun    <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      pwm_prev_q <= pwm_s;
      meas_valid <= 1'b0;

      if (frame_start || state_q == StMeasure) begin
        cnt_q    <= cnt_cur;
        high_q   <= high_nxt;
        offset_q <= offset_nxt;
        pulses_q <= pulses_nxt;
        seen_q   <= seen_nxt;
        ovf_q    <= ovf_nxt;
      end

      if (frame_start) begin
        // In IDLE the strobe only arms; there is no finished frame to report.
        if (state_q == StMeasure) begin
          period_out <= period_nxt;
          duty_out   <= high_q;
          offset_out <= offset_q;
          pulse_cnt  <= pulses_q;
          no_pulse   <= (pulses_q == '0);
          overrun    <= ovf_q;
          meas_valid <= 1'b1;
        end
        state_q <= StMeasure;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture.
module tb_pwm_capture;

`ifdef PWM_CAP_SYNC_EN
  localparam int SyncD = 2;
`else
  localparam int SyncD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fs_a, pwm_a, fs_b, pwm_b;

  logic [12:0] offset_a, duty_a, period_a;
  logic [3:0]  pcnt_a;
  logic        nop_a, ovr_a, valid_a;

  logic [3:0]  offset_b, duty_b, period_b;
  logic [3:0]  pcnt_b;
  logic        nop_b, ovr_b, valid_b;

  pwm_capture #(.WIDTH(13), .PCNT_W(4)) u_dut_a (
    .clk_in     (clk),
    .rst_in     (rst),
    .frame_start(fs_a),
    .pwm_in     (pwm_a),
    .offset_out (offset_a),
    .duty_out   (duty_a),
    .period_out (period_a),
    .pulse_cnt  (pcnt_a),
    .no_pulse   (nop_a),
    .overrun    (ovr_a),
    .meas_valid (valid_a)
  );

  pwm_capture #(.WIDTH(4), .PCNT_W(4)) u_dut_b (
    .clk_in     (clk),
    .rst_in     (rst),
    .frame_start(fs_b),
    .pwm_in     (pwm_b),
    .offset_out (offset_b),
    .duty_out   (duty_b),
    .period_out (period_b),
    .pulse_cnt  (pcnt_b),
    .no_pulse   (nop_b),
    .overrun    (ovr_b),
    .meas_valid (valid_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int nv_saved;

  always @(negedge clk) if (valid_a) n_valid++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one frame on DUT a (sel=0) or b (sel=1); pwm high on counts a1..b1, a2..b2.
  task automatic run_frame(input int sel, input int len, input int a1, input int b1,
                           input int a2, input int b2);
    logic hi;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      hi = ((c >= a1) && (c <= b1)) || ((c >= a2) && (c <= b2));
      if (sel == 0) begin
        fs_a  = (c == 0);
        pwm_a = hi;
      end else begin
        fs_b  = (c == 0);
        pwm_b = hi;
      end
    end
  endtask

  task automatic check_a(input string tag, input int off, input int duty, input int per,
                         input int pc, input int nop);
    check_eq({tag, ".offset"}, int'(offset_a), off);
    check_eq({tag, ".duty"}, int'(duty_a), duty);
    check_eq({tag, ".period"}, int'(period_a), per);
    check_eq({tag, ".pulses"}, int'(pcnt_a), pc);
    check_eq({tag, ".no_pulse"}, int'(nop_a), nop);
    check_eq({tag, ".overrun"}, int'(ovr_a), 0);
    check_eq({tag, ".valid_low"}, int'(valid_a), 0);
  endtask

  initial begin
    rst = 1'b1; fs_a = 1'b0; pwm_a = 1'b0; fs_b = 1'b0; pwm_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.offset", int'(offset_a), 0);
    check_eq("rst.period", int'(period_a), 0);
    check_eq("rst.duty", int'(duty_a), 0);
    check_eq("rst.valid", int'(valid_a), 0);
    rst = 1'b0;

    // First frame only arms the block.
    run_frame(0, 5000, 1000, 2499, 1, 0);
    check_eq("arm.nvalid", n_valid, 0);
    run_frame(0, 5000, 100, 199, 3000, 3299);
    check_eq("single.nvalid", n_valid, 1);
    check_a("single", 1000 + SyncD, 1500, 5000, 1, 0);
    run_frame(0, 5000, 1, 0, 1, 0);
    check_a("two", 100 + SyncD, 400, 5000, 2, 0);
    run_frame(0, 5000, 0, 4999, 1, 0);
    check_a("low", 0, 0, 5000, 0, 1);
    run_frame(0, 5000, 0, 4999, 1, 0);
    check_a("rise_hi", SyncD, 5000 - SyncD, 5000, 1, 0);
    run_frame(0, 5000, 1, 0, 1, 0);
    check_a("high", 0, 5000, 5000, 1, 0);

    // Back-to-back strobes make 1-cycle frames.
    run_frame(0, 1, 1, 0, 1, 0);
    run_frame(0, 1, 1, 0, 1, 0);
    run_frame(0, 10, 1, 0, 1, 0);
    check_eq("b2b.nvalid", n_valid, 8);
    check_eq("b2b.period", int'(period_a), 1);
    check_eq("b2b.duty", int'(duty_a), 0);
    check_eq("b2b.no_pulse", int'(nop_a), 1);

    // Reset in mid-frame discards it.
    run_frame(0, 5000, 1000, 2499, 1, 0);
    run_frame(0, 2000, 1000, 2499, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst.period", int'(period_a), 0);
    check_eq("midrst.duty", int'(duty_a), 0);
    check_eq("midrst.offset", int'(offset_a), 0);
    check_eq("midrst.pulses", int'(pcnt_a), 0);
    check_eq("midrst.valid", int'(valid_a), 0);
    rst = 1'b0;
    fs_a = 1'b0;
    pwm_a = 1'b0;
    nv_saved = n_valid;
    run_frame(0, 5000, 1000, 2499, 1, 0);
    check_eq("rearm.nvalid", n_valid - nv_saved, 0);
    run_frame(0, 5000, 1, 0, 1, 0);
    check_eq("after_rst.nvalid", n_valid - nv_saved, 1);
    check_a("after_rst", 1000 + SyncD, 1500, 5000, 1, 0);

    // Overrun on the 4-bit instance.
    run_frame(1, 20, 1, 0, 1, 0);
    run_frame(1, 20, 1, 0, 1, 0);
    run_frame(1, 10, 1, 0, 1, 0);
    check_eq("ovr.period", int'(period_b), 15);
    check_eq("ovr.overrun", int'(ovr_b), 1);
    check_eq("ovr.no_pulse", int'(nop_b), 1);
    run_frame(1, 10, 1, 0, 1, 0);
    check_eq("norm.period", int'(period_b), 10);
    check_eq("norm.overrun", int'(ovr_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
